// File: rtl/wb_shared_mem_arbiter_if.sv
// Bus bundle for wb_shared_mem_arbiter: Wishbone host port, core load/store port
// and the single-port memory port. "slave" is the arbiter's view, "master" the surroundings'.
interface wb_shared_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    logic              core_req;
    logic              core_we;
    logic [3:0]        core_sel;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_ack;
    logic [31:0]       core_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  core_req, core_we, core_sel, core_addr, core_wdata,
        output core_ack, core_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output core_req, core_we, core_sel, core_addr, core_wdata,
        input  core_ack, core_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/wb_shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the Wishbone host and the core.
// Optional grant/conflict statistics counters are built when ARB_STATS_EN is defined.
module wb_shared_mem_arbiter #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MEM_LAT   = 1
) (
    input  logic wb_clk_i,
    input  logic rst_n,
    wb_shared_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] stat_host_cnt,
    output logic [15:0] stat_core_cnt,
    output logic [15:0] stat_conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic {OWN_CORE = 1'b0, OWN_HOST = 1'b1} owner_t;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    logic              mask_host_q, mask_host_d;
    logic              mask_core_q, mask_core_d;
    logic              we_q, we_d;
    logic              abort_q, abort_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              wbs_ack_q, wbs_ack_d;
    logic              core_ack_q, core_ack_d;
    logic [31:0]       host_dat_q, host_dat_d;
    logic [31:0]       core_dat_q, core_dat_d;

    logic host_hit;
    logic host_req;
    logic host_ok;
    logic core_ok;
    logic grant_host;
    logic grant_core;
    logic unused_adr_bits;

    assign host_hit = (bus.wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign host_req = bus.wbs_cyc_i & bus.wbs_stb_i & host_hit;
    assign unused_adr_bits = ^bus.wbs_adr_i[1:0];

    // A requester acked in the previous cycle may still be holding the old request.
    assign host_ok    = host_req & ~mask_host_q;
    assign core_ok    = bus.core_req & ~mask_core_q;
    assign grant_host = host_ok & (~core_ok | (last_grant_q == OWN_CORE));
    assign grant_core = core_ok & (~host_ok | (last_grant_q == OWN_HOST));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        abort_d      = abort_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 4'b0000;
        wbs_ack_d    = 1'b0;
        core_ack_d   = 1'b0;
        mask_host_d  = 1'b0;
        mask_core_d  = 1'b0;
        host_dat_d   = (wbs_ack_q && !we_q) ? bus.mem_rdata : host_dat_q;
        core_dat_d   = (core_ack_q && !we_q) ? bus.mem_rdata : core_dat_q;

        unique case (state_q)
            IDLE: begin
                if (grant_host) begin
                    owner_d     = OWN_HOST;
                    we_d        = bus.wbs_we_i;
                    abort_d     = 1'b0;
                    mem_addr_d  = bus.wbs_adr_i[ADDR_W+1:2];
                    mem_wdata_d = bus.wbs_dat_i;
                    mem_we_d    = bus.wbs_we_i ? bus.wbs_sel_i : 4'b0000;
                    mem_en_d    = 1'b1;
                    state_d     = ISSUE;
                end else if (grant_core) begin
                    owner_d     = OWN_CORE;
                    we_d        = bus.core_we;
                    abort_d     = 1'b0;
                    mem_addr_d  = bus.core_addr;
                    mem_wdata_d = bus.core_wdata;
                    mem_we_d    = bus.core_we ? bus.core_sel : 4'b0000;
                    mem_en_d    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = CNT_INIT;
                if (MEM_LAT == 1) begin
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                last_grant_d = owner_q;
                mask_host_d  = (owner_q == OWN_HOST);
                mask_core_d  = (owner_q == OWN_CORE);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A host that leaves the cycle still lets the memory access finish, but gets no ack.
        if ((state_q == ISSUE || state_q == WAIT) && owner_q == OWN_HOST && !bus.wbs_cyc_i) begin
            abort_d = 1'b1;
        end
        if (state_d == ACK) begin
            wbs_ack_d  = (owner_q == OWN_HOST) && !abort_d;
            core_ack_d = (owner_q == OWN_CORE);
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CORE;
            last_grant_q <= OWN_CORE;
            mask_host_q  <= 1'b0;
            mask_core_q  <= 1'b0;
            we_q         <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= 2'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            wbs_ack_q    <= 1'b0;
            core_ack_q   <= 1'b0;
            host_dat_q   <= 32'h0;
            core_dat_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mask_host_q  <= mask_host_d;
            mask_core_q  <= mask_core_d;
            we_q         <= we_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wbs_ack_q    <= wbs_ack_d;
            core_ack_q   <= core_ack_d;
            host_dat_q   <= host_dat_d;
            core_dat_q   <= core_dat_d;
        end
    end

    // Read data is presented straight from memory during the ack cycle, then held.
    assign bus.wbs_ack_o  = wbs_ack_q;
    assign bus.wbs_dat_o  = (wbs_ack_q && !we_q) ? bus.mem_rdata : host_dat_q;
    assign bus.core_ack   = core_ack_q;
    assign bus.core_rdata = (core_ack_q && !we_q) ? bus.mem_rdata : core_dat_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_host_q, stat_host_d;
    logic [15:0] stat_core_q, stat_core_d;
    logic [15:0] stat_conf_q, stat_conf_d;

    always_comb begin
        stat_host_d = stat_host_q;
        stat_core_d = stat_core_q;
        stat_conf_d = stat_conf_q;
        if (state_q == IDLE && grant_host && stat_host_q != 16'hFFFF) begin
            stat_host_d = stat_host_q + 16'd1;
        end
        if (state_q == IDLE && grant_core && stat_core_q != 16'hFFFF) begin
            stat_core_d = stat_core_q + 16'd1;
        end
        if (state_q == IDLE && host_req && bus.core_req && stat_conf_q != 16'hFFFF) begin
            stat_conf_d = stat_conf_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stat_host_q <= 16'd0;
            stat_core_q <= 16'd0;
            stat_conf_q <= 16'd0;
        end else begin
            stat_host_q <= stat_host_d;
            stat_core_q <= stat_core_d;
            stat_conf_q <= stat_conf_d;
        end
    end

    assign stat_host_cnt     = stat_host_q;
    assign stat_core_cnt     = stat_core_q;
    assign stat_conflict_cnt = stat_conf_q;
`endif

endmodule

// File: doc/wb_shared_mem_arbiter.md
Name: wb_shared_mem_arbiter

Overview:
- Shares one single-port word memory between two requesters:
  - the Caravel Wishbone host (wbs_* slave port);
  - the RISC-V core data bus.
- Sits inside wrapped_tholin_riscv, between the wrapper's Wishbone pins, the core load/store port and the on-chip SRAM macro.
- Round-robin arbitration, one access in flight, fixed memory read latency.

Parameters:
- ADDR_W, 10, word-address width of the shared memory.
- BASE_ADDR, 32'h3000_0000, host window base; the window is 2^(ADDR_W+2) bytes.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.

Ports:
- wb_clk_i  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  host bus cycle
- wbs_stb_i  in  1  host strobe
- wbs_we_i  in  1  host write
- wbs_sel_i  in  4  host byte selects
- wbs_adr_i  in  32  host byte address
- wbs_dat_i  in  32  host write data
- wbs_ack_o  out  1  host acknowledge, one-cycle pulse
- wbs_dat_o  out  32  host read data
- core_req  in  1  core request, held until core_ack
- core_we  in  1  core write
- core_sel  in  4  core byte enables
- core_addr  in  ADDR_W  core word address
- core_wdata  in  32  core write data
- core_ack  out  1  core acknowledge, one-cycle pulse
- core_rdata  out  32  core read data
- mem_en  out  1  memory access strobe
- mem_we  out  4  memory byte write enables; all zero means read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE, last_grant = CORE, and every output to 0.
  - This applies mid-transaction: mem_en drops immediately and no ack is issued for the aborted access.
- Host request: host_req = wbs_cyc_i & wbs_stb_i & hit.
  - hit: wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
  - Word address: wbs_adr_i[ADDR_W+1:2].
  - Misses are ignored: no ack, no memory access.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Arbitrate among host_req and core_req.
  - If both are active, grant the requester that is not last_grant.
  - Latch owner, address, data, byte selects and we; go to ISSUE.
  - The requester acked in the immediately preceding ACK cycle is masked for this one IDLE cycle (stale-request guard).
- ISSUE (1 cycle):
  - mem_en = 1, mem_addr / mem_wdata from the latch.
  - mem_we = sel if write, else 4'b0000.
  - Load the latency counter with MEM_LAT-1.
  - Go to WAIT, or directly to ACK when MEM_LAT = 1.
- WAIT:
  - Decrement the counter; at 0 go to ACK.
  - mem_en = 0 in WAIT.
- ACK (1 cycle):
  - Capture mem_rdata into the owner's read-data register; update last_grant = owner.
  - Pulse the owner's ack for exactly this cycle.
  - Go to IDLE.
- Latency, request sampled in IDLE at cycle 0:
  - mem_en at cycle 1; ack at cycle 1+MEM_LAT.
  - Throughput: one access per 2+MEM_LAT cycles, plus 1 IDLE cycle.
- Writes use the same sequence and latency as reads.
- Read data: wbs_dat_o / core_rdata hold their last captured value until the next read by the same requester. Write acks leave read data unchanged.
- Host abort: if wbs_cyc_i drops after grant, the memory access still completes but wbs_ack_o is suppressed. Core requests cannot be aborted.
- Requests arriving outside IDLE wait; they are never lost as long as the requester holds them.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds output ports:
  - stat_host_cnt[15:0]: host grants.
  - stat_core_cnt[15:0]: core grants.
  - stat_conflict_cnt[15:0]: IDLE cycles where both requests were active, unmasked.
- All counters reset to 0, increment on grant / conflict, and saturate at 16'hFFFF.
- When undefined, these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Host write 32'hDEADBEEF, sel 4'hF, adr 32'h3000_0010, MEM_LAT=1 -> mem_en at cycle 1 with mem_addr 4, mem_we 4'hF; wbs_ack_o at cycle 2. A following read returns 32'hDEADBEEF on wbs_dat_o.
- Core read addr 10'h004, MEM_LAT=3 -> core_ack 4 cycles after sampling, core_rdata 32'hDEADBEEF, mem_we 4'h0.
- host_req and core_req asserted together and held for 4 accesses -> grants alternate H,C,H,C (last_grant reset = CORE, so host first); stat_conflict_cnt = 4 with ARB_STATS_EN.
- Host adr 32'h2000_0000 -> no mem_en and no wbs_ack_o for 20 cycles; a core request is still served.
- Host read granted, wbs_cyc_i dropped during WAIT -> mem access completes, wbs_ack_o never pulses, next core request is granted normally.
- rst_n pulled low during WAIT -> mem_en, acks and read data go to 0 immediately; after release the held core_req is re-served with a full latency sequence.
